// File: rtl/row_packer.sv
// rtl/row_packer.sv - packs WORDS stream words into one row, then pulses a round-robin slot code
module row_packer #(
    parameter int WORD_W = 17,
    parameter int WORDS  = 256,
    parameter int SLOTS  = 4
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     frame_clear,
    input  logic                     in_valid,
    input  logic [WORD_W-1:0]        in_data,
    output logic                     in_ready,
    output logic [WORDS*WORD_W-1:0]  data,
    output logic [2:0]               control,
    output logic                     slot_done
);

    localparam int              CNT_W    = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam logic [CNT_W-1:0] LAST    = CNT_W'(WORDS - 1);
    localparam logic [2:0]      SLOT_MAX = 3'(SLOTS);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        EMIT = 2'd2
    } state_t;

    state_t           state;
    state_t           next_state;
    logic [CNT_W-1:0] word_cnt;
    logic [2:0]       slot;
    logic             accept;
    logic             last_word;

    assign in_ready  = (state == FILL);
    assign accept    = in_valid && in_ready;
    assign last_word = (word_cnt == LAST);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    next_state = FILL;
            FILL:    if (accept && last_word) next_state = EMIT;
            EMIT:    next_state = FILL;
            default: next_state = IDLE;
        endcase
        if (frame_clear) begin
            next_state = FILL;
        end
    end

    // data is never cleared between rows; each new row overwrites it word by word
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            word_cnt  <= '0;
            slot      <= 3'd1;
            data      <= '0;
            control   <= 3'd0;
            slot_done <= 1'b0;
        end else if (frame_clear) begin
            word_cnt  <= '0;
            slot      <= 3'd1;
            control   <= 3'd0;
            slot_done <= 1'b0;
        end else begin
            case (state)
                FILL: begin
                    if (accept) begin
                        data[int'(word_cnt)*WORD_W +: WORD_W] <= in_data;
                        if (last_word) begin
                            word_cnt  <= '0;
                            control   <= slot;
                            slot_done <= (slot == SLOT_MAX);
                        end else begin
                            word_cnt <= word_cnt + 1'b1;
                        end
                    end
                end
                EMIT: begin
                    control   <= 3'd0;
                    slot_done <= 1'b0;
                    slot      <= (slot == SLOT_MAX) ? 3'd1 : slot + 3'd1;
                end
                default: begin
                    control   <= 3'd0;
                    slot_done <= 1'b0;
                end
            endcase
        end
    end

endmodule
